// File: rtl/sipo_rx.sv
// LSB-first serial-to-parallel receiver with SOF framing, a valid/ready output
// register, and one-cycle framing-error / overrun pulses.
module sipo_rx #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             sin_en,
   input  logic             sof,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             busy,
   output logic             framing_err,
   output logic             overrun
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] shift_r;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] dout_r;
   logic             dout_valid_r;
   logic             busy_r;
   logic             framing_err_r;
   logic             overrun_r;
   logic [WIDTH-1:0] word_s;

   // Word as it would look with the current serial bit shifted in.
   assign word_s = {sin, shift_r[WIDTH-1:1]};

   // Receive FSM, shift register, output register and status pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= IDLE;
         shift_r       <= '0;
         cnt_r         <= CNT_ZERO;
         dout_r        <= '0;
         dout_valid_r  <= 1'b0;
         busy_r        <= 1'b0;
         framing_err_r <= 1'b0;
         overrun_r     <= 1'b0;
      end else begin
         framing_err_r <= 1'b0;
         overrun_r     <= 1'b0;
         // Consumption; a completion below on the same edge overrides this.
         if (dout_valid_r && dout_ready) begin
            dout_valid_r <= 1'b0;
         end
         case (state_r)
            IDLE: begin
               if (sin_en && sof) begin
                  shift_r <= word_s;
                  cnt_r   <= CNT_ONE;
                  state_r <= SHIFT;
                  busy_r  <= 1'b1;
               end
            end
            SHIFT: begin
               if (sin_en) begin
                  shift_r <= word_s;
                  if (sof) begin
                     // Restart: the current bit is bit 0 of a fresh frame.
                     cnt_r         <= CNT_ONE;
                     framing_err_r <= 1'b1;
                  end else if (cnt_r == CNT_LAST) begin
                     cnt_r   <= CNT_ZERO;
                     state_r <= IDLE;
                     busy_r  <= 1'b0;
                     if (!dout_valid_r || dout_ready) begin
                        dout_r       <= word_s;
                        dout_valid_r <= 1'b1;
                     end else begin
                        overrun_r <= 1'b1;
                     end
                  end else begin
                     cnt_r <= cnt_r + CNT_ONE;
                  end
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= CNT_ZERO;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign dout        = dout_r;
   assign dout_valid  = dout_valid_r;
   assign busy        = busy_r;
   assign framing_err = framing_err_r;
   assign overrun     = overrun_r;

endmodule

// File: tb/tb_sipo_rx.sv
// Directed-vector bench for sipo_rx at WIDTH=4; expected values are hand-computed.
module tb_sipo_rx;

   logic       clk;
   logic       rst;
   logic       sin;
   logic       sin_en;
   logic       sof;
   logic [3:0] dout;
   logic       dout_valid;
   logic       dout_ready;
   logic       busy;
   logic       framing_err;
   logic       overrun;

   int vec_cnt;
   int err_cnt;

   sipo_rx #(.WIDTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .sin         (sin),
      .sin_en      (sin_en),
      .sof         (sof),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .dout_ready  (dout_ready),
      .busy        (busy),
      .framing_err (framing_err),
      .overrun     (overrun)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bit_in(input logic b, input logic s);
      sin    = b;
      sin_en = 1'b1;
      sof    = s;
      tick();
      sin_en = 1'b0;
      sof    = 1'b0;
   endtask

   task automatic send_word(input logic [3:0] w);
      for (int i = 0; i < 4; i++) begin
         bit_in(w[i], (i == 0) ? 1'b1 : 1'b0);
      end
   endtask

   initial begin
      vec_cnt    = 0;
      err_cnt    = 0;
      rst        = 1'b1;
      sin        = 1'b0;
      sin_en     = 1'b0;
      sof        = 1'b0;
      dout_ready = 1'b1;
      #1;
      chk("rst_dout",  32'(dout), 32'h0);
      chk("rst_valid", 32'(dout_valid), 32'h0);
      chk("rst_busy",  32'(busy), 32'h0);
      chk("rst_ferr",  32'(framing_err), 32'h0);
      chk("rst_ovr",   32'(overrun), 32'h0);
      tick();
      rst = 1'b0;
      tick();

      // Single word 1,0,1,1 -> 4'hD
      bit_in(1'b1, 1'b1);
      chk("w1_busy1", 32'(busy), 32'h1);
      bit_in(1'b0, 1'b0);
      chk("w1_busy2", 32'(busy), 32'h1);
      bit_in(1'b1, 1'b0);
      chk("w1_busy3", 32'(busy), 32'h1);
      chk("w1_nvalid", 32'(dout_valid), 32'h0);
      bit_in(1'b1, 1'b0);
      chk("w1_dout",  32'(dout), 32'hD);
      chk("w1_valid", 32'(dout_valid), 32'h1);
      chk("w1_idle",  32'(busy), 32'h0);
      tick();
      chk("w1_consumed", 32'(dout_valid), 32'h0);
      chk("w1_hold",     32'(dout), 32'hD);

      // Stall: 5 idle cycles between bits 2 and 3
      bit_in(1'b1, 1'b1);
      bit_in(1'b0, 1'b0);
      repeat (5) tick();
      chk("st_busy", 32'(busy), 32'h1);
      chk("st_nvalid", 32'(dout_valid), 32'h0);
      bit_in(1'b1, 1'b0);
      bit_in(1'b1, 1'b0);
      chk("st_dout",  32'(dout), 32'hD);
      chk("st_valid", 32'(dout_valid), 32'h1);
      chk("st_ferr",  32'(framing_err), 32'h0);
      chk("st_ovr",   32'(overrun), 32'h0);
      tick();

      // Backpressure: 4'h3 held, 4'hA dropped
      dout_ready = 1'b0;
      send_word(4'h3);
      chk("bp_dout1",  32'(dout), 32'h3);
      chk("bp_valid1", 32'(dout_valid), 32'h1);
      chk("bp_ovr0",   32'(overrun), 32'h0);
      send_word(4'hA);
      chk("bp_dout2",  32'(dout), 32'h3);
      chk("bp_valid2", 32'(dout_valid), 32'h1);
      chk("bp_ovr1",   32'(overrun), 32'h1);
      tick();
      chk("bp_ovr_pulse", 32'(overrun), 32'h0);
      chk("bp_still",     32'(dout_valid), 32'h1);
      dout_ready = 1'b1;
      tick();
      chk("bp_drain", 32'(dout_valid), 32'h0);
      chk("bp_dout3", 32'(dout), 32'h3);

      // Simultaneous accept: 4'h3 held, 4'h5 completes with dout_ready
      dout_ready = 1'b0;
      send_word(4'h3);
      bit_in(1'b1, 1'b1);
      bit_in(1'b0, 1'b0);
      bit_in(1'b1, 1'b0);
      chk("sa_held", 32'(dout), 32'h3);
      dout_ready = 1'b1;
      bit_in(1'b0, 1'b0);
      chk("sa_dout",  32'(dout), 32'h5);
      chk("sa_valid", 32'(dout_valid), 32'h1);
      chk("sa_ovr",   32'(overrun), 32'h0);
      tick();
      chk("sa_drain", 32'(dout_valid), 32'h0);

      // Frame restart after 2 bits, then 0,1,1,0 -> 4'h6
      bit_in(1'b1, 1'b1);
      bit_in(1'b1, 1'b0);
      chk("fr_ferr0", 32'(framing_err), 32'h0);
      bit_in(1'b0, 1'b1);
      chk("fr_ferr1", 32'(framing_err), 32'h1);
      chk("fr_busy",  32'(busy), 32'h1);
      bit_in(1'b1, 1'b0);
      chk("fr_ferr_pulse", 32'(framing_err), 32'h0);
      bit_in(1'b1, 1'b0);
      bit_in(1'b0, 1'b0);
      chk("fr_dout",  32'(dout), 32'h6);
      chk("fr_valid", 32'(dout_valid), 32'h1);

      // Reset mid-frame while 4'h6 is still held
      dout_ready = 1'b0;
      bit_in(1'b1, 1'b1);
      bit_in(1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("rm_dout",  32'(dout), 32'h0);
      chk("rm_valid", 32'(dout_valid), 32'h0);
      chk("rm_busy",  32'(busy), 32'h0);
      tick();
      rst = 1'b0;
      bit_in(1'b1, 1'b0);
      bit_in(1'b1, 1'b0);
      bit_in(1'b1, 1'b0);
      chk("rm_ignored", 32'(busy), 32'h0);
      chk("rm_nvalid",  32'(dout_valid), 32'h0);
      dout_ready = 1'b1;
      send_word(4'hF);
      chk("rm_dout_f",  32'(dout), 32'hF);
      chk("rm_valid_f", 32'(dout_valid), 32'h1);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-in parallel-out deserializer: the receive end of the team's LSB-first serial word link. It collects WIDTH bits, strobed by a bit-enable and framed by a start-of-frame marker, into a parallel word. It presents that word on a valid/ready output register. It flags frame restarts and dropped words, and sits between the serial link input and the word-consuming logic.

## Interface
- WIDTH, 4, bits per word; legal range 2..32.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- sin  input  1  serial data bit, LSB of the word first.
- sin_en  input  1  bit strobe; sin is sampled only on edges where sin_en=1.
- sof  input  1  start of frame; qualified by sin_en and marks the current bit as bit 0.
- dout  output  WIDTH  received word; held stable while dout_valid=1.
- dout_valid  output  1  output register holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout on an edge where dout_valid=1 and dout_ready=1.
- busy  output  1  a frame is partially received (state SHIFT).
- framing_err  output  1  one-cycle pulse: a frame was restarted before completion.
- overrun  output  1  one-cycle pulse: a completed word was dropped because the output register was occupied.

## Operation
- Reset (asynchronous, immediate on rst=1) drives the following values:
  - state=IDLE, shift register=0, bit counter=0.
  - dout=0, dout_valid=0, busy=0, framing_err=0, overrun=0.
- Shift rule: on every accepted bit, shift <= {sin, shift[WIDTH-1:1]}. After WIDTH bits, shift[0] holds the first bit received.
- Bit counter: width is ceil(log2(WIDTH)). It counts accepted bits in the current frame.
- State IDLE:
  - sin_en=1 with sof=1: capture the bit, set counter=1, go to SHIFT.
  - sin_en=1 with sof=0: the bit is ignored and the block stays in IDLE.
  - sof=1 with sin_en=0: ignored.
- State SHIFT:
  - sin_en=0: hold; no timeout.
  - sin_en=1, sof=0, counter<WIDTH-1: capture the bit and increment the counter.
  - sin_en=1, sof=0, counter=WIDTH-1: capture the final bit, complete the word (see below), clear the counter, go to IDLE.
  - sin_en=1, sof=1: discard the partial word and pulse framing_err. The current bit becomes bit 0 of a new frame: counter=1, stay in SHIFT.
- Word completion, using the assembled word {sin, shift[WIDTH-1:1]}:
  - If dout_valid=0, or dout_ready=1 on the same edge: load dout with the assembled word and set dout_valid=1.
  - Otherwise: the new word is dropped, dout and dout_valid are unchanged, and overrun pulses.
- Output handshake:
  - An edge with dout_valid=1, dout_ready=1 and no completion clears dout_valid.
  - dout keeps its last value after it is consumed.
  - dout_ready while dout_valid=0 has no effect.
- busy = (state==SHIFT), registered.

## Timing
- Latency: when the final bit is sampled at edge k, dout and dout_valid=1 are visible from edge k to edge k+1.
- Throughput: one bit per clock is sustained when sin_en is held high. A word completes every WIDTH cycles when sof is asserted on each bit 0.
- Back-to-back frames: sof may accompany the bit on the edge immediately after a completion edge; no idle cycle is required.
- framing_err and overrun are registered, asserted for exactly the one cycle after the triggering edge.
- Simultaneous completion and acceptance on the same edge: the new word is loaded, dout_valid stays 1, and no overrun is raised.
- rst asserted mid-frame: the partial word is lost and all outputs return to reset values immediately. The first edge after rst deasserts requires sof to start a frame.

## Test plan
- Single word, WIDTH=4, dout_ready=1:
  - Stimulus: sin=1,0,1,1 on consecutive sin_en cycles, sof on the first bit.
  - Response: dout=4'hD with dout_valid=1 for one cycle, one cycle after the 4th bit; busy high for 3 cycles.
- Stall tolerance:
  - Stimulus: the same bits with sin_en low for 5 cycles between bits 2 and 3.
  - Response: dout=4'hD; no error pulses; busy held through the gap.
- Backpressure and overrun, dout_ready=0:
  - Stimulus: send word 4'h3, then word 4'hA back-to-back.
  - Response: dout stays 4'h3 and dout_valid=1; overrun pulses once at completion of 4'hA. Raising dout_ready clears dout_valid the next edge.
- Simultaneous accept:
  - Stimulus: dout_ready pulsed on the same edge that word 4'h5 completes, while 4'h3 is held.
  - Response: dout=4'h5, dout_valid remains 1, no overrun.
- Frame restart:
  - Stimulus: sof after 2 bits, then bits 0,1,1,0 with sof on the first.
  - Response: framing_err pulses once, then dout=4'h6.
- Reset mid-frame:
  - Stimulus: assert rst asynchronously after 2 bits.
  - Response: dout=0, dout_valid=0, busy=0 immediately. Bits without sof afterwards are ignored; a full sof frame 1,1,1,1 then yields 4'hF.
